// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, drives the instruction memory address and captures
// the fetched word, its PC and PC+4 into the IF/ID register.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h00000000,
    parameter logic [31:0] EXC_VECTOR = 32'h80000004,
    parameter bit          EARLY_JUMP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        exc_req,
    output logic [31:0] pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] p4_q, p4_d;
    logic [31:0] cnt_q, cnt_d;

    logic [31:0] seq, jtarget, redir_pc;
    logic        is_jump;

    always_comb begin
        seq      = pc_q + 32'd4;
        jtarget  = {seq[31:28], imem_instr[25:0], 2'b00};
        redir_pc = redirect_target & ~32'h3;
        is_jump  = EARLY_JUMP &&
                   ((imem_instr[31:26] == 6'h02) || (imem_instr[31:26] == 6'h03));

        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        p4_d    = p4_q;
        cnt_d   = cnt_q;

        // Exception beats redirect beats stall; both flushes insert the all-zero nop.
        if (exc_req || redirect_valid) begin
            pc_d    = exc_req ? EXC_VECTOR : redir_pc;
            valid_d = 1'b0;
            instr_d = '0;
            ipc_d   = '0;
            p4_d    = '0;
        end else if (!stall) begin
            pc_d    = is_jump ? jtarget : seq;
            valid_d = 1'b1;
            instr_d = imem_instr;
            ipc_d   = pc_q;
            p4_d    = seq;
            cnt_d   = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
            p4_q    <= '0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            p4_q    <= p4_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign if_id_valid    = valid_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc       = ipc_q;
    assign if_id_pc_plus4 = p4_q;
    assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus randomized
// traffic checked against a per-edge behavioural model.
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr, imem_instr;
    logic        stall, redirect_valid, exc_req;
    logic [31:0] redirect_target;
    logic [31:0] pc, if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count;
    logic        if_id_valid;

    // Second copy with early jump disabled, sharing all control inputs.
    logic [31:0] imem_addr0, imem_instr0, pc0, if_id_instr0, if_id_pc0, if_id_pc_plus40, fetch_count0;
    logic        if_id_valid0;

    logic [31:0] mem [0:63];

    int checks = 0;
    int passed = 0;

    // expected state
    logic [31:0] e_pc, e_instr, e_ipc, e_p4, e_cnt;
    logic        e_v;

    always #5 clk = ~clk;

    assign imem_instr  = mem[imem_addr[7:2]];
    assign imem_instr0 = mem[imem_addr0[7:2]];

    instruction_fetch_stage #(.RESET_PC(32'h0), .EXC_VECTOR(32'h80000004), .EARLY_JUMP(1'b1)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .exc_req(exc_req), .pc(pc), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4), .fetch_count(fetch_count)
    );

    instruction_fetch_stage #(.RESET_PC(32'h0), .EXC_VECTOR(32'h80000004), .EARLY_JUMP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .imem_addr(imem_addr0), .imem_instr(imem_instr0),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .exc_req(exc_req), .pc(pc0), .if_id_valid(if_id_valid0), .if_id_instr(if_id_instr0),
        .if_id_pc(if_id_pc0), .if_id_pc_plus4(if_id_pc_plus40), .fetch_count(fetch_count0)
    );

    function automatic logic [192:0] act();
        return {imem_addr, pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count};
    endfunction

    function automatic logic [192:0] exp_st();
        return {e_pc, e_pc, e_v, e_instr, e_ipc, e_p4, e_cnt};
    endfunction

    task automatic model_reset();
        e_pc = 32'h0; e_v = 1'b0; e_instr = 0; e_ipc = 0; e_p4 = 0; e_cnt = 0;
    endtask

    // Spec rules for one rising edge, written from the priority list.
    task automatic model_edge();
        logic [31:0] w, nxt;
        w   = mem[e_pc[7:2]];
        nxt = e_pc + 32'd4;
        if (exc_req) begin
            e_pc = 32'h80000004; e_v = 0; e_instr = 0; e_ipc = 0; e_p4 = 0;
        end else if (redirect_valid) begin
            e_pc = {redirect_target[31:2], 2'b00}; e_v = 0; e_instr = 0; e_ipc = 0; e_p4 = 0;
        end else if (!stall) begin
            e_v = 1; e_instr = w; e_ipc = e_pc; e_p4 = nxt; e_cnt = e_cnt + 1;
            if (w[31:26] == 6'h02 || w[31:26] == 6'h03)
                e_pc = {nxt[31:28], w[25:0], 2'b00};
            else
                e_pc = nxt;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; redirect_valid = 0; exc_req = 0; redirect_target = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h20040004;
        mem[1] = 32'h24050005;
        mem[2] = 32'h2006000a;
        mem[3] = 32'h00853820;
    endtask

    task automatic test_reset();
        load_prog();
        do_reset();
        checks++;
        if ({pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count} !== {32'h0, 1'b0, 128'h0}) begin
            $display("FAIL reset_state got pc=%h v=%b instr=%h ipc=%h p4=%h cnt=%0d want all zero",
                     pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count);
        end else passed++;
        step();
        checks++;
        if ({pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4} !== {32'h4, 1'b1, 32'h20040004, 32'h0, 32'h4})
            $display("FAIL first_fetch got pc=%h v=%b instr=%h ipc=%h p4=%h", pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4);
        else passed++;
        step();
        checks++;
        if ({pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count} !==
            {32'h8, 1'b1, 32'h24050005, 32'h4, 32'h8, 32'd2})
            $display("FAIL second_fetch got pc=%h v=%b instr=%h ipc=%h p4=%h cnt=%0d",
                     pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count);
        else passed++;
    endtask

    task automatic test_early_jump();
        load_prog();
        mem[1] = 32'h0c000003;
        do_reset();
        step();
        step();
        checks++;
        if ({pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4} !== {32'hC, 1'b1, 32'h0c000003, 32'h4, 32'h8})
            $display("FAIL early_jal got pc=%h v=%b instr=%h ipc=%h p4=%h", pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4);
        else passed++;
        checks++;
        if ({pc0, if_id_valid0, if_id_instr0, if_id_pc_plus40} !== {32'h8, 1'b1, 32'h0c000003, 32'h8})
            $display("FAIL no_early_jump got pc=%h v=%b instr=%h p4=%h want pc=8", pc0, if_id_valid0, if_id_instr0, if_id_pc_plus40);
        else passed++;
        checks++;
        if (act() !== exp_st()) $display("FAIL early_jump_model got %h want %h", act(), exp_st());
        else passed++;
    endtask

    task automatic test_stall();
        load_prog();
        do_reset();
        step();
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count} !==
                {32'h8, 1'b1, 32'h24050005, 32'h4, 32'h8, 32'd2})
                $display("FAIL stall_hold%0d got pc=%h v=%b instr=%h cnt=%0d", i, pc, if_id_valid, if_id_instr, fetch_count);
            else passed++;
        end
        stall = 0;
        step();
        checks++;
        if ({pc, if_id_instr, if_id_pc, fetch_count} !== {32'hC, 32'h2006000a, 32'h8, 32'd3})
            $display("FAIL stall_release got pc=%h instr=%h ipc=%h cnt=%0d", pc, if_id_instr, if_id_pc, fetch_count);
        else passed++;
    endtask

    task automatic test_redirect_stall();
        stall = 1; redirect_valid = 1; redirect_target = 32'h00000013;
        step();
        idle_inputs();
        checks++;
        if ({pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count} !== {32'h10, 1'b0, 96'h0, 32'd3})
            $display("FAIL redirect_over_stall got pc=%h v=%b instr=%h cnt=%0d", pc, if_id_valid, if_id_instr, fetch_count);
        else passed++;
    endtask

    task automatic test_exc_priority();
        step();
        exc_req = 1; redirect_valid = 1; redirect_target = 32'h40;
        step();
        idle_inputs();
        checks++;
        if ({pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count} !== {32'h80000004, 1'b0, 96'h0, 32'd4})
            $display("FAIL exc_over_redirect got pc=%h v=%b instr=%h cnt=%0d", pc, if_id_valid, if_id_instr, fetch_count);
        else passed++;
    endtask

    task automatic test_async_reset_and_wrap();
        load_prog();
        do_reset();
        step(); step(); step();
        #3;
        reset = 1;
        model_reset();
        #1;
        checks++;
        if ({pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count} !== {32'h0, 1'b0, 128'h0})
            $display("FAIL async_reset got pc=%h v=%b instr=%h cnt=%0d", pc, if_id_valid, if_id_instr, fetch_count);
        else passed++;
        @(posedge clk);
        #1;
        checks++;
        if (act() !== exp_st()) $display("FAIL reset_held got %h want %h", act(), exp_st());
        else passed++;
        reset = 0;
        redirect_valid = 1; redirect_target = 32'hFFFFFFFC;
        step();
        idle_inputs();
        step();
        checks++;
        if ({pc, if_id_valid, if_id_pc, if_id_pc_plus4} !== {32'h0, 1'b1, 32'hFFFFFFFC, 32'h0})
            $display("FAIL pc_wrap got pc=%h v=%b ipc=%h p4=%h", pc, if_id_valid, if_id_pc, if_id_pc_plus4);
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if ($urandom_range(0, 3) == 0) mem[i][31:26] = ($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03;
        end
        do_reset();
        for (int c = 0; c < 400; c++) begin
            exc_req         = ($urandom_range(0, 19) == 0);
            redirect_valid  = ($urandom_range(0, 9) == 0);
            redirect_target = $urandom;
            stall           = ($urandom_range(0, 3) == 0);
            step();
            checks++;
            if (act() !== exp_st()) $display("FAIL random_c%0d got %h want %h", c, act(), exp_st());
            else passed++;
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_early_jump();
        test_stall();
        test_redirect_stall();
        test_exc_priority();
        test_async_reset_and_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Fetch stage of the MIPS pipeline; sits directly upstream of the instruction memory.
- Owns the program counter and drives the memory word address. The memory returns the instruction combinationally in the same cycle.
- Captures instruction, PC and PC+4 into the IF/ID pipeline register.
- Handles stall, redirect and exception flush, plus optional early resolution of j/jal in IF.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
EXC_VECTOR, 32'h80000004, PC value loaded on exception request.
EARLY_JUMP, 1, 1 = resolve j/jal (opcode 6'h02/6'h03) in IF with no bubble; 0 = treat them as sequential.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
imem_addr  output  32  byte address to the instruction memory; equals pc.
imem_instr  input  32  instruction word returned combinationally for imem_addr.
stall  input  1  hazard unit: hold the PC and the IF/ID register.
redirect_valid  input  1  branch/jr/jalr resolved downstream; load redirect_target.
redirect_target  input  32  new PC on redirect.
exc_req  input  1  exception/interrupt; load EXC_VECTOR.
pc  output  32  current fetch PC.
if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
if_id_instr  output  32  latched instruction.
if_id_pc  output  32  PC of the latched instruction.
if_id_pc_plus4  output  32  PC+4 of the latched instruction.
fetch_count  output  32  number of instructions captured with valid=1.

Behaviour:
- Reset (async, reset=1):
  - pc=RESET_PC.
  - if_id_valid=0, if_id_instr=0, if_id_pc=0, if_id_pc_plus4=0.
  - fetch_count=0.
  - Held while reset is high; the first fetch is at the first rising edge after release.
- imem_addr is the combinational pc. The fetch latency is 1 cycle: the instruction at pc appears on if_id_* after the next rising edge.
- seq = pc+4 (32-bit, wraps 32'hFFFFFFFC -> 32'h00000000).
- jtarget = {seq[31:28], imem_instr[25:0], 2'b00}.
- Per rising edge, strict priority:
  1. exc_req=1:
     - pc<=EXC_VECTOR.
     - IF/ID <= bubble (valid=0, instr=0, pc=0, pc_plus4=0).
     - stall and redirect_valid are ignored.
  2. redirect_valid=1:
     - pc<={redirect_target[31:2],2'b00}; low two bits are forced to 0.
     - IF/ID <= bubble.
     - Overrides stall.
  3. stall=1:
     - pc, IF/ID and fetch_count all hold.
  4. Otherwise:
     - IF/ID <= {1, imem_instr, pc, seq}.
     - fetch_count <= fetch_count+1; wraps at 2^32.
     - pc <= jtarget when EARLY_JUMP=1 and imem_instr[31:26] is 6'h02 or 6'h03; otherwise pc <= seq.
     - The jump instruction itself is still latched (jal needs if_id_pc_plus4 for $ra).
- Bubble encoding: the all-zero word (sll $0,$0,0). Downstream treats it as a nop regardless of valid.
- A redirect or exception never increments fetch_count on that edge.
- Combinations:
  - Stall together with redirect: the redirect wins. The stalled instruction in IF/ID is discarded (the bubble replaces it).
  - Early jump fetched in a stalled cycle: no effect until the stall releases. Its target is then computed from the same held pc/instr.
- No internal state machine beyond the PC/IF-ID registers. All registers update only on clk or async reset.

Test Plan:
1. Reset release with RESET_PC=0 and memory word0=32'h20040004, word1=32'h24050005. Two free cycles -> pc 0->4->8; IF/ID = {1, 32'h20040004, 0, 4}, then {1, 32'h24050005, 4, 8}; fetch_count=2.
2. EARLY_JUMP=1 with word1=32'h0c000003 (jal 0x0C). Edge with pc=4 -> pc=32'h0000000C next; IF/ID = {1, 32'h0c000003, 4, 8}; no bubble. Repeat with EARLY_JUMP=0 -> pc=8.
3. stall=1 for 3 cycles at pc=8 -> pc, if_id_* and fetch_count unchanged for all 3. On release, normal advance to pc=32'h0C.
4. redirect_valid=1, redirect_target=32'h00000013, with stall=1 -> pc=32'h00000010; if_id_valid=0, if_id_instr=0; fetch_count unchanged.
5. exc_req=1 and redirect_valid=1 (target 32'h40) on the same edge -> pc=32'h80000004; IF/ID bubble. The redirect is lost.
6. Assert reset asynchronously mid-cycle at pc=32'h0C with valid IF/ID -> outputs clear immediately, not at the next edge; pc=RESET_PC. Wrap check: redirect to 32'hFFFFFFFC, then one free edge -> pc=0, if_id_pc_plus4=0.
